mips_exec_unit: RTL and testbench

- Execute-stage block of the single-cycle MIPS core.
- Contains three parts:
  - a combinational 32-bit ALU, driven by rs/rt or immediate data;
  - combinational branch-decision logic;
  - three 32-bit performance counters: total cycles, taken branches, jumps. The counters stop while the CPU is halted on a syscall.
- Sits between the register file and the PC/RAM path. result1 also serves as the memory address.

---
 rtl/mips_exec_unit_if.sv | 33 +++
 rtl/mips_exec_unit.sv | 126 ++++++++++++
 tb/tb_mips_exec_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_exec_unit_if.sv
// Execute-stage bus: operands/control from decode and regfile, ALU/branch results and counters back.
// The master drives the operands and strobes; the execute unit is the slave.
interface mips_exec_unit_if;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  alu_op;
    logic [4:0]  shamt;
    logic [31:0] result1;
    logic [31:0] result2;
    logic        equal;
    logic        beq;
    logic        bne;
    logic        blez;
    logic        bgtz;
    logic        bz;
    logic        rt_bit;
    logic        branch_out;
    logic        jmp;
    logic        syscall;
    logic [31:0] count_all;
    logic [31:0] count_branch;
    logic [31:0] count_jmp;

    modport master (
        output x, y, alu_op, shamt, beq, bne, blez, bgtz, bz, rt_bit, jmp, syscall,
        input  result1, result2, equal, branch_out, count_all, count_branch, count_jmp
    );

    modport slave (
        input  x, y, alu_op, shamt, beq, bne, blez, bgtz, bz, rt_bit, jmp, syscall,
        output result1, result2, equal, branch_out, count_all, count_branch, count_jmp
    );
endinterface

// File: rtl/mips_exec_unit.sv
// MIPS execute stage: zero-latency ALU and branch decision, plus registered cycle/branch/jump counters
// (1-cycle latency, frozen while halted on a syscall). Define EXEC_COUNT_SATURATE_EN to saturate instead of wrap.
module mips_exec_unit #(
    parameter logic [31:0] HALT_CODE = 32'd34
) (
    input  logic             clk,
    input  logic             clr,
    mips_exec_unit_if.slave  bus
);

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRA  = 4'd1;
    localparam logic [3:0] OP_SRL  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;

    logic [63:0] prod;
    logic [31:0] res1;
    logic [31:0] res2;
    logic        x_neg;
    logic        x_zero;
    logic        halt;

    logic [31:0] count_all_q,    count_all_d;
    logic [31:0] count_branch_q, count_branch_d;
    logic [31:0] count_jmp_q,    count_jmp_d;

    // ALU
    always_comb begin
        res1 = '0;
        res2 = '0;
        prod = $signed({{32{bus.x[31]}}, bus.x}) * $signed({{32{bus.y[31]}}, bus.y});
        case (bus.alu_op)
            OP_SLL:  res1 = bus.y << bus.shamt;
            OP_SRA:  res1 = $signed(bus.y) >>> bus.shamt;
            OP_SRL:  res1 = bus.y >> bus.shamt;
            OP_MUL: begin
                res1 = prod[31:0];
                res2 = prod[63:32];
            end
            OP_DIV: begin
                // Divide-by-zero and the single overflowing quotient get fixed results
                if (bus.y == 32'd0) begin
                    res1 = 32'hFFFF_FFFF;
                    res2 = bus.x;
                end else if (bus.x == 32'h8000_0000 && bus.y == 32'hFFFF_FFFF) begin
                    res1 = 32'h8000_0000;
                    res2 = 32'd0;
                end else begin
                    res1 = $signed(bus.x) / $signed(bus.y);
                    res2 = $signed(bus.x) % $signed(bus.y);
                end
            end
            OP_ADD:  res1 = bus.x + bus.y;
            OP_SUB:  res1 = bus.x - bus.y;
            OP_AND:  res1 = bus.x & bus.y;
            OP_OR:   res1 = bus.x | bus.y;
            OP_XOR:  res1 = bus.x ^ bus.y;
            OP_NOR:  res1 = ~(bus.x | bus.y);
            OP_SLT:  res1 = {31'd0, $signed(bus.x) < $signed(bus.y)};
            OP_SLTU: res1 = {31'd0, bus.x < bus.y};
            default: res1 = '0;
        endcase
    end

    assign bus.result1 = res1;
    assign bus.result2 = res2;
    assign bus.equal   = (bus.x == bus.y);

    // Branch decision on x only for the compare-with-zero forms
    assign x_neg  = bus.x[31];
    assign x_zero = (bus.x == 32'd0);

    assign bus.branch_out = (bus.beq  &  bus.equal)
                          | (bus.bne  & ~bus.equal)
                          | (bus.blez & (x_neg | x_zero))
                          | (bus.bgtz & ~x_neg & ~x_zero)
                          | (bus.bz   & (bus.rt_bit ? ~x_neg : x_neg));

    // A syscall whose service code is not HALT_CODE stalls the PC and freezes the counters
    assign halt = bus.syscall & (bus.x != HALT_CODE);

    function automatic logic [31:0] bump(input logic [31:0] v);
`ifdef EXEC_COUNT_SATURATE_EN
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
`else
        return v + 32'd1;
`endif
    endfunction

    always_comb begin
        count_all_d    = count_all_q;
        count_branch_d = count_branch_q;
        count_jmp_d    = count_jmp_q;
        if (!halt) begin
            count_all_d = bump(count_all_q);
            if (bus.branch_out) count_branch_d = bump(count_branch_q);
            if (bus.jmp)        count_jmp_d    = bump(count_jmp_q);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_all_q    <= '0;
            count_branch_q <= '0;
            count_jmp_q    <= '0;
        end else begin
            count_all_q    <= count_all_d;
            count_branch_q <= count_branch_d;
            count_jmp_q    <= count_jmp_d;
        end
    end

    assign bus.count_all    = count_all_q;
    assign bus.count_branch = count_branch_q;
    assign bus.count_jmp    = count_jmp_q;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed bench for mips_exec_unit: stimulus pushes expected values into a scoreboard queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_exec_unit;

    logic clk = 1'b0;
    logic clr;

    mips_exec_unit_if bus ();

    mips_exec_unit #(.HALT_CODE(32'd34)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam int K_R1 = 0, K_R2 = 1, K_EQ = 2, K_BR = 3, K_CA = 4, K_CB = 5, K_CJ = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] pick(input int k);
        case (k)
            K_R1:    return bus.result1;
            K_R2:    return bus.result2;
            K_EQ:    return {31'd0, bus.equal};
            K_BR:    return {31'd0, bus.branch_out};
            K_CA:    return bus.count_all;
            K_CB:    return bus.count_branch;
            K_CJ:    return bus.count_jmp;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    task automatic expect_cnt(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] j);
        expect_val({tag, "_all"}, K_CA, a);
        expect_val({tag, "_branch"}, K_CB, b);
        expect_val({tag, "_jmp"}, K_CJ, j);
    endtask

    // Monitor: outputs are stable at the falling edge, half a cycle after inputs change
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                c   = sb.pop_front();
                act = pick(c.kind);
                n_cmp++;
                if (act !== c.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    // Consumes exactly one rising edge and leaves time just after it
    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        bus.beq = 0; bus.bne = 0; bus.blez = 0; bus.bgtz = 0; bus.bz = 0; bus.rt_bit = 0;
        bus.jmp = 0; bus.syscall = 0;
    endtask

    task automatic alu(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] e1, input logic [31:0] e2);
        bus.alu_op = op; bus.x = a; bus.y = b; bus.shamt = sh;
        expect_val({name, "_r1"}, K_R1, e1);
        expect_val({name, "_r2"}, K_R2, e2);
        step();
    endtask

    // s = {beq, bne, blez, bgtz, bz}
    task automatic br(input string name, input logic [4:0] s, input logic rt, input logic [31:0] a,
                      input logic [31:0] b, input logic e);
        {bus.beq, bus.bne, bus.blez, bus.bgtz, bus.bz} = s;
        bus.rt_bit = rt; bus.x = a; bus.y = b;
        expect_val(name, K_BR, {31'd0, e});
        step();
    endtask

    initial begin
        clr = 1'b1;
        bus.x = 0; bus.y = 0; bus.alu_op = 0; bus.shamt = 0;
        clear_strobes();
        expect_cnt("reset", 32'd0, 32'd0, 32'd0);
        step();
        clr = 1'b0;

        alu("add",  4'd5,  32'd7, 32'd5, 5'd0, 32'd12, 32'd0);
        alu("sub",  4'd6,  32'd7, 32'd5, 5'd0, 32'd2,  32'd0);
        alu("and",  4'd7,  32'd7, 32'd5, 5'd0, 32'd5,  32'd0);
        alu("or",   4'd8,  32'd7, 32'd5, 5'd0, 32'd7,  32'd0);
        alu("xor",  4'd9,  32'd7, 32'd5, 5'd0, 32'd2,  32'd0);
        alu("nor",  4'd10, 32'd7, 32'd5, 5'd0, 32'hFFFF_FFF8, 32'd0);
        alu("slt",  4'd11, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 32'd0);
        alu("sltu", 4'd12, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0);
        alu("sll",  4'd0,  32'd0, 32'h8000_0000, 5'd4, 32'd0, 32'd0);
        alu("sra",  4'd1,  32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 32'd0);
        alu("srl",  4'd2,  32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 32'd0);
        alu("lui",  4'd0,  32'd0, 32'h0000_ABCD, 5'd16, 32'hABCD_0000, 32'd0);
        alu("mul",  4'd3,  32'h0001_0000, 32'h0001_0000, 5'd0, 32'd0, 32'd1);
        alu("muln", 4'd3,  32'hFFFF_FFFF, 32'd2, 5'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        alu("div",  4'd4,  32'hFFFF_FFF9, 32'd2, 5'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        alu("div0", 4'd4,  32'hFFFF_FFF9, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        alu("divov",4'd4,  32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 32'd0);
        alu("op13", 4'd13, 32'd7, 32'd5, 5'd0, 32'd0, 32'd0);

        bus.x = 32'h1234; bus.y = 32'h1234;
        expect_val("equal_hi", K_EQ, 32'd1);
        step();
        bus.y = 32'h1235;
        expect_val("equal_lo", K_EQ, 32'd0);
        step();

        br("beq_eq",   5'b10000, 1'b0, 32'd9, 32'd9, 1'b1);
        br("bne_eq",   5'b01000, 1'b0, 32'd9, 32'd9, 1'b0);
        br("bne_ne",   5'b01000, 1'b0, 32'd9, 32'd3, 1'b1);
        br("blez_0",   5'b00100, 1'b0, 32'd0, 32'd3, 1'b1);
        br("bgtz_0",   5'b00010, 1'b0, 32'd0, 32'd3, 1'b0);
        br("bgtz_pos", 5'b00010, 1'b0, 32'd1, 32'd3, 1'b1);
        br("bltz_neg", 5'b00001, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        br("bgez_neg", 5'b00001, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        br("none",     5'b00000, 1'b0, 32'd9, 32'd9, 1'b0);

        // Counting: clear mid-cycle, then 10 edges with 3 branches and 2 jumps
        clr = 1'b1;
        #1 clr = 1'b0;
        bus.x = 32'd5; bus.y = 32'd5;
        for (int i = 0; i < 10; i++) begin
            clear_strobes();
            bus.beq = (i < 3);
            bus.jmp = (i == 5 || i == 7);
            step();
        end
        expect_cnt("count", 32'd10, 32'd3, 32'd2);

        // Halting syscall: every strobe active yet nothing counts
        bus.syscall = 1; bus.x = 32'd10; bus.y = 32'd10; bus.beq = 1; bus.jmp = 1;
        repeat (5) step();
        expect_cnt("halt", 32'd10, 32'd3, 32'd2);

        // Non-halting service code is an ordinary cycle
        clear_strobes();
        bus.syscall = 1; bus.x = 32'd34; bus.y = 32'd0;
        step();
        expect_cnt("sys34", 32'd11, 32'd3, 32'd2);
        step();

        // Asynchronous clear between edges
        clear_strobes();
        clr = 1'b1;
        expect_cnt("aclr", 32'd0, 32'd0, 32'd0);
        step();
        clr = 1'b0;

        // Preload count_all to all-ones, then one more counting edge
        force dut.count_all_d = 32'hFFFF_FFFF;
        step();
        release dut.count_all_d;
        bus.x = bus.x ^ 32'd1;
        expect_val("preload", K_CA, 32'hFFFF_FFFF);
        step();
`ifdef EXEC_COUNT_SATURATE_EN
        expect_val("saturate", K_CA, 32'hFFFF_FFFF);
`else
        expect_val("wrap", K_CA, 32'd0);
`endif
        step();

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
